cv32e41s_rvfi_instr_obi_tracker: RTL

Instruction-side OBI transaction tracker that sits directly upstream of the RVFI instruction-fetch record. It pairs each granted instruction request with its response in order and emits one registered `rvfi_obi_instr_t` record per completed fetch. It also emits records for PMP-blocked fetches that never reach the bus. The tracker only observes the OBI instruction interface and never drives it.

---
 rtl/cv32e41s_pkg.sv | 17 +
 rtl/cv32e41s_rvfi_pkg.sv | 14 +
 rtl/cv32e41s_rvfi_sync_fifo.sv | 79 +++++++
 rtl/cv32e41s_rvfi_instr_obi_tracker.sv | 96 +++++++++
 4 files changed

// File: rtl/cv32e41s_pkg.sv
// Shared core types used by the RVFI trackers: OBI instruction request payload
// and instruction-side response as seen by the fetch stage.
package cv32e41s_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  memtype;
        logic [2:0]  prot;
        logic        dbg;
    } obi_inst_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } inst_resp_t;

endpackage

// File: rtl/cv32e41s_rvfi_pkg.sv
// RVFI-side record types and instantiation defaults for the OBI trackers.
package cv32e41s_rvfi_pkg;

    import cv32e41s_pkg::*;

    localparam int RVFI_INSTR_OBI_DEPTH = 2;

    typedef struct packed {
        obi_inst_req_t req_payload;
        inst_resp_t    resp_payload;
        logic          pmp_err;
    } rvfi_obi_instr_t;

endpackage

// File: rtl/cv32e41s_rvfi_sync_fifo.sv
// Generic synchronous FIFO with a type parameter; head is read combinationally.
// Shared by the instruction and data side RVFI OBI trackers.
module cv32e41s_rvfi_sync_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  T                 wdata_i,
    input  logic             pop_i,
    output T                 rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;
    T                 mem_q [DEPTH];

    // Explicit wrap so non power-of-two depths never index past DEPTH-1.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            wptr_d = ptr_inc(wptr_q);
        end
        if (pop_ok) begin
            rptr_d = ptr_inc(rptr_q);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/cv32e41s_rvfi_instr_obi_tracker.sv
// Pairs granted instruction OBI requests with their in-order responses and
// emits one registered RVFI fetch record per response or PMP-blocked fetch.
module cv32e41s_rvfi_instr_obi_tracker
    import cv32e41s_pkg::*;
    import cv32e41s_rvfi_pkg::*;
#(
    parameter int  DEPTH = RVFI_INSTR_OBI_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             obi_req_i,
    input  logic             obi_gnt_i,
    input  obi_inst_req_t    obi_req_payload_i,
    input  logic             obi_rvalid_i,
    input  inst_resp_t       obi_resp_payload_i,
    input  logic             pmp_blk_valid_i,
    input  obi_inst_req_t    pmp_blk_payload_i,
    output logic             rvfi_valid_o,
    output rvfi_obi_instr_t  rvfi_obi_instr_o,
    output logic [CNT_W-1:0] outstanding_o,
    output logic             protocol_err_o
);

    logic            push;
    logic            pop_ok;
    logic            fifo_full;
    logic            fifo_empty;
    obi_inst_req_t   fifo_head;
    logic            push_drop;
    logic            rvalid_empty;
    logic            pmp_drop;
    logic            pmp_record;

    logic            rvfi_valid_q, rvfi_valid_d;
    rvfi_obi_instr_t rvfi_obi_instr_q, rvfi_obi_instr_d;
    logic            protocol_err_q, protocol_err_d;

    assign push = obi_req_i && obi_gnt_i;

    cv32e41s_rvfi_sync_fifo #(
        .DEPTH (DEPTH),
        .T     (obi_inst_req_t)
    ) req_fifo_i (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (obi_req_payload_i),
        .pop_i   (obi_rvalid_i),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding_o)
    );

    assign pop_ok       = obi_rvalid_i && !fifo_empty;
    assign push_drop    = push && fifo_full && !pop_ok;
    assign rvalid_empty = obi_rvalid_i && fifo_empty;
    // A bus response always takes priority over a PMP block in the same cycle.
    assign pmp_drop     = pmp_blk_valid_i && (!fifo_empty || obi_rvalid_i);
    assign pmp_record   = pmp_blk_valid_i && fifo_empty && !obi_rvalid_i;

    always_comb begin
        rvfi_valid_d     = 1'b0;
        rvfi_obi_instr_d = rvfi_obi_instr_q;
        protocol_err_d   = protocol_err_q | push_drop | rvalid_empty | pmp_drop;
        if (pop_ok) begin
            rvfi_valid_d                  = 1'b1;
            rvfi_obi_instr_d.req_payload  = fifo_head;
            rvfi_obi_instr_d.resp_payload = obi_resp_payload_i;
            rvfi_obi_instr_d.pmp_err      = 1'b0;
        end else if (pmp_record) begin
            rvfi_valid_d                  = 1'b1;
            rvfi_obi_instr_d.req_payload  = pmp_blk_payload_i;
            rvfi_obi_instr_d.resp_payload = '0;
            rvfi_obi_instr_d.pmp_err      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvfi_valid_q     <= 1'b0;
            rvfi_obi_instr_q <= '0;
            protocol_err_q   <= 1'b0;
        end else begin
            rvfi_valid_q     <= rvfi_valid_d;
            rvfi_obi_instr_q <= rvfi_obi_instr_d;
            protocol_err_q   <= protocol_err_d;
        end
    end

    assign rvfi_valid_o     = rvfi_valid_q;
    assign rvfi_obi_instr_o = rvfi_obi_instr_q;
    assign protocol_err_o   = protocol_err_q;

endmodule
